div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, meaning number of requesters (>=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester operation request.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester acceptance.
REQ-007 SHALL have port req_x, input, NREQ*N, packed per-requester dividends.
REQ-008 SHALL have port req_y, input, NREQ*N, packed per-requester divisors.
REQ-009 SHALL have port req_signed, input, NREQ, per-requester signed-operation flag.
REQ-010 SHALL have port rsp_valid, output, 1, result available.
REQ-011 SHALL have port rsp_ready, input, 1, result consumer ready.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ), index of the requester owning the result.
REQ-013 SHALL have port rsp_q, output, N, quotient.
REQ-014 SHALL have port rsp_r, output, N, remainder as produced by the divider (magnitude, no sign fix-up).
REQ-015 SHALL have port rsp_dbz, output, 1, divide-by-zero flag.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL share one SRTDivider among NREQ requesters, one operation in flight at a time.
REQ-018 SHALL implement FSM IDLE -> CLEAR -> LAUNCH -> WAIT -> RESP -> IDLE.
REQ-019 IDLE: SHALL grant round-robin among asserted req_valid, searching upward from pointer ptr with wrap; req_ready[g]=1 combinationally for winner g only; all req_ready=0 outside IDLE.
REQ-020 On accept (req_valid[g] & req_ready[g]): SHALL register x, y, signed and g, set ptr <= (g+1) mod NREQ, and go to CLEAR.
REQ-021 CLEAR: SHALL drive divider reset high for exactly one cycle; divider reset is (rst OR state==CLEAR).
REQ-022 LAUNCH: SHALL drive divider start high for exactly one cycle, then go to WAIT.
REQ-023 SHALL hold divider x, y and signedInput stable from CLEAR until leaving WAIT (divider q depends combinationally on them).
REQ-024 WAIT: on divider done=1, SHALL register q, r and divByZeroEx into rsp_q/rsp_r/rsp_dbz and go to RESP.
REQ-025 RESP: SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1; transfer cycle returns to IDLE; no accept in the transfer cycle.
REQ-026 Latency accept -> rsp_valid SHALL be N+6 cycles for y!=0 and 5 cycles for y==0.
REQ-027 When no req_valid is set in IDLE, SHALL stay in IDLE with ptr unchanged.
REQ-028 req_valid deasserted before acceptance SHALL have no effect; requesters hold valid and operands until accepted.
REQ-029 rsp_valid, rsp_dbz SHALL be 0 and rsp_q, rsp_r, rsp_id hold the last transferred values outside RESP.

Reset
REQ-030 rst SHALL force state=IDLE, ptr=0, rsp_valid=0, rsp_dbz=0, rsp_q=0, rsp_r=0, rsp_id=0, busy=0, req_ready=0 in the reset cycle.
REQ-031 rst in any state (including mid-WAIT) SHALL abort the operation, discard its result and reset the divider in the same cycle.
REQ-032 First accept SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-033 SHALL place the FSM state enum in a shared divider package (div_pkg).
REQ-034 SHALL instantiate one SRTDivider #(N) and one sub-module rr_picker #(NREQ) (combinational round-robin winner from valid vector and ptr); no other sub-modules.

Verification
REQ-035 Unsigned, req0: x=100, y=7 -> rsp_q=14, rsp_r=2, rsp_dbz=0, rsp_id=0, rsp_valid 38 cycles after accept (N=32).
REQ-036 Signed, req1: x=-100 (0xFFFFFF9C), y=7 -> rsp_q=0xFFFFFFF2, rsp_r=2, rsp_id=1.
REQ-037 req3: x=5, y=0 -> rsp_dbz=1, rsp_valid 5 cycles after accept.
REQ-038 ptr=0, req0 and req2 valid together and held -> req0 served first, then req2; next simultaneous req0+req2 -> req0 (ptr=3 wraps).
REQ-039 rsp_ready low 10 cycles in RESP with req1 pending -> rsp_* stable, req_ready all 0; req1 accepted in cycle after transfer.
REQ-040 rst pulsed mid-WAIT -> no rsp_valid for aborted op; fresh x=9, y=3 then returns rsp_q=3, rsp_r=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types for the divider arbiter: top-level FSM states and divider core phases.
// Latency: none (types only).
// Backpressure: not applicable.
package div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_PREP,
    PH_ITER,
    PH_FIX,
    PH_DONE
  } div_phase_e;

endpackage

// File: rtl/SRTDivider.sv
// Iterative radix-2 divider on operand magnitudes; quotient sign applied combinationally from x/y.
// Latency: start -> done is N+3 cycles, or 2 cycles for a zero divisor; done holds until reset.
// Backpressure: none; x, y and signedInput must stay stable from start until the result is taken.
module SRTDivider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         signedInput,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         done,
  output logic         divByZeroEx
);
  import div_pkg::*;

  localparam int CW = $clog2(N + 1);

  div_phase_e   r_phase, w_phase_nxt;
  logic [N-1:0] r_quo, r_div, r_rem, r_qmag, r_rmag;
  logic         r_dbz;
  logic [CW-1:0] r_cnt;
  logic [N-1:0] w_ax, w_ay;
  logic [N:0]   w_sh, w_diff;
  logic         w_neg;

  assign w_ax   = (signedInput && x[N-1]) ? (~x + N'(1)) : x;
  assign w_ay   = (signedInput && y[N-1]) ? (~y + N'(1)) : y;
  assign w_neg  = signedInput && (x[N-1] ^ y[N-1]);
  assign w_sh   = {r_rem, r_quo[N-1]};
  assign w_diff = w_sh - {1'b0, r_div};

  // phase register
  always_ff @(posedge clk) begin
    if (reset) r_phase <= PH_IDLE;
    else       r_phase <= w_phase_nxt;
  end

  // phase sequencing; a zero divisor skips the iterations entirely
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_IDLE: if (start) w_phase_nxt = PH_PREP;
      PH_PREP: w_phase_nxt = (w_ay == '0) ? PH_DONE : PH_ITER;
      PH_ITER: if (r_cnt == CW'(N - 1)) w_phase_nxt = PH_FIX;
      PH_FIX:  w_phase_nxt = PH_DONE;
      default: w_phase_nxt = r_phase;
    endcase
  end

  // shift-subtract datapath: one quotient bit per ITER cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_quo  <= '0;
      r_div  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_qmag <= '0;
      r_rmag <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_phase)
        PH_PREP: begin
          r_quo  <= w_ax;
          r_div  <= w_ay;
          r_rem  <= '0;
          r_cnt  <= '0;
          r_dbz  <= (w_ay == '0);
          r_qmag <= '1;
          r_rmag <= w_ax;
        end
        PH_ITER: begin
          r_cnt <= r_cnt + CW'(1);
          if (!w_diff[N]) begin
            r_rem <= w_diff[N-1:0];
            r_quo <= {r_quo[N-2:0], 1'b1};
          end else begin
            r_rem <= w_sh[N-1:0];
            r_quo <= {r_quo[N-2:0], 1'b0};
          end
        end
        PH_FIX: begin
          r_qmag <= r_quo;
          r_rmag <= r_rem;
        end
        default: ;
      endcase
    end
  end

  assign done        = (r_phase == PH_DONE);
  assign divByZeroEx = done && r_dbz;
  assign q           = w_neg ? (~r_qmag + N'(1)) : r_qmag;
  assign r           = r_rmag;

endmodule

// File: rtl/rr_picker.sv
// Round-robin winner: first asserted valid at or above the pointer, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the winner is accepted.
module rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_valid,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic                    o_vld,
  output logic [$clog2(NREQ)-1:0] o_idx
);
  localparam int IW = $clog2(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;

  // doubling the vector lets a plain shift act as a rotate by ptr
  assign w_dbl = {i_valid, i_valid};
  assign w_rot = NREQ'(w_dbl >> i_ptr);

  // lowest set bit of the rotated vector is the nearest requester at or above ptr
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IW'(i);
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_vld = |i_valid;
  assign o_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];

endmodule

// File: rtl/div_arbiter.sv
// Shares one divider among NREQ requesters, round-robin, one operation in flight.
// Latency: accept -> rsp_valid is N+6 cycles, or 5 cycles for a zero divisor.
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_ready.
module div_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*N-1:0]       req_x,
  input  logic [NREQ*N-1:0]       req_y,
  input  logic [NREQ-1:0]         req_signed,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [N-1:0]            rsp_q,
  output logic [N-1:0]            rsp_r,
  output logic                    rsp_dbz,
  output logic                    busy
);
  import div_pkg::*;

  localparam int IW = $clog2(NREQ);

  arb_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, r_owner, r_id;
  logic [N-1:0]  r_x, r_y, r_q, r_r;
  logic          r_sgn, r_dbz;
  logic          w_gnt_vld, w_accept;
  logic [IW-1:0] w_gnt_idx;
  logic [N-1:0]  w_sel_x, w_sel_y;
  logic          w_sel_s;
  logic          w_div_rst, w_div_start, w_div_done, w_div_dbz;
  logic [N-1:0]  w_div_q, w_div_r;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_vld   (w_gnt_vld),
    .o_idx   (w_gnt_idx)
  );

  // CLEAR gives every operation a freshly reset divider
  assign w_div_rst = rst || (r_state == ST_CLEAR);

  SRTDivider #(.N(N)) u_div (
    .clk         (clk),
    .reset       (w_div_rst),
    .start       (w_div_start),
    .x           (r_x),
    .y           (r_y),
    .signedInput (r_sgn),
    .q           (w_div_q),
    .r           (w_div_r),
    .done        (w_div_done),
    .divByZeroEx (w_div_dbz)
  );

  // operand mux for the granted requester
  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    w_sel_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == IW'(i)) begin
        w_sel_x = req_x[i*N +: N];
        w_sel_y = req_y[i*N +: N];
        w_sel_s = req_signed[i];
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and handshake outputs; everything quiet while rst is high
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    busy        = 1'b0;
    rsp_valid   = 1'b0;
    w_div_start = 1'b0;
    w_accept    = 1'b0;
    if (!rst) begin
      busy = (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            req_ready[w_gnt_idx] = 1'b1;
            w_accept             = req_valid[w_gnt_idx];
            w_state_nxt          = ST_CLEAR;
          end
        end
        ST_CLEAR:  w_state_nxt = ST_LAUNCH;
        ST_LAUNCH: begin
          w_div_start = 1'b1;
          w_state_nxt = ST_WAIT;
        end
        ST_WAIT:   if (w_div_done) w_state_nxt = ST_RESP;
        ST_RESP: begin
          rsp_valid = 1'b1;
          if (rsp_ready) w_state_nxt = ST_IDLE;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // operand capture on accept, result capture when the divider finishes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sgn   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
      r_id    <= '0;
    end else begin
      if (w_accept) begin
        r_x     <= w_sel_x;
        r_y     <= w_sel_y;
        r_sgn   <= w_sel_s;
        r_owner <= w_gnt_idx;
        r_ptr   <= (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + IW'(1);
      end
      if (r_state == ST_WAIT && w_div_done) begin
        r_q   <= w_div_q;
        r_r   <= w_div_r;
        r_dbz <= w_div_dbz;
        r_id  <= r_owner;
      end
    end
  end

  assign rsp_dbz = rsp_valid && r_dbz;
  assign rsp_q   = rst ? '0 : r_q;
  assign rsp_r   = rst ? '0 : r_r;
  assign rsp_id  = rst ? '0 : r_id;

endmodule
